pc_ctrl_sequencer: RTL

- Instruction-side counterpart of the `processor` program-counter unit: reads the current `PC`, fetches a 16-bit control word from a local program memory, and drives the `BADR`, `bra` and `hlt` inputs of the PC unit.
- Replaces the hand-driven branch/halt stimulus with a programmable sequencer (jump, counted loop, timed or resumable halt).
- Sits directly beside `processor`: `PC` out of it, `BADR`/`bra`/`hlt` back into it.

---
 rtl/pc_ctrl_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pc_ctrl_sequencer.sv
// Programmable branch/halt sequencer that drives BADR/bra/hlt of the PC unit from a local program memory.
// Optional build macro PCSEQ_ILLEGAL_TRAP_EN: opcodes 0x5-0xF branch to TRAP_ADDR and pulse `illegal`.
module pc_ctrl_sequencer #(
  parameter int AW = 10,
  parameter int DW = 16,
  parameter int CW = 10
`ifdef PCSEQ_ILLEGAL_TRAP_EN
  ,
  parameter logic [AW-1:0] TRAP_ADDR = '0
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] PC,
  input  logic          resume,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic [AW-1:0] BADR,
  output logic          bra,
  output logic          hlt,
  output logic          busy_loop
`ifdef PCSEQ_ILLEGAL_TRAP_EN
  ,
  output logic          illegal
`endif
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_LDC  = 4'h2;
  localparam logic [3:0] OP_LOOP = 4'h3;
  localparam logic [3:0] OP_HLT  = 4'h4;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_SQUASH = 2'd1,
    S_HALT   = 2'd2
  } state_e;

  logic [DW-1:0] prog_mem [0:(1<<AW)-1];
  logic [DW-1:0] word;
  logic [3:0]    opcode;
  logic [AW-1:0] operand;

  state_e        state_q,    state_d;
  logic          bra_q,      bra_d;
  logic          hlt_q,      hlt_d;
  logic [AW-1:0] badr_q,     badr_d;
  logic [CW-1:0] loop_cnt_q, loop_cnt_d;
  logic [CW-1:0] halt_cnt_q, halt_cnt_d;
  logic          illegal_q,  illegal_d;

  // Asynchronous read means a same-cycle write at PC still decodes the old word.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      prog_mem[prog_addr] <= prog_data;
    end
  end

  assign word    = prog_mem[PC];
  assign opcode  = word[DW-1:DW-4];
  assign operand = word[AW-1:0];

  if (DW - 4 > AW) begin : g_spare
    logic unused_spare;
    assign unused_spare = ^word[DW-5:AW];
  end

  always_comb begin
    state_d    = state_q;
    bra_d      = 1'b0;
    hlt_d      = hlt_q;
    badr_d     = badr_q;
    loop_cnt_d = loop_cnt_q;
    halt_cnt_d = halt_cnt_q;
    illegal_d  = 1'b0;
    case (state_q)
      S_RUN: begin
        case (opcode)
          OP_NOP: ;
          OP_JMP: begin
            bra_d   = 1'b1;
            badr_d  = operand;
            state_d = S_SQUASH;
          end
          OP_LDC: loop_cnt_d = CW'(operand);
          OP_LOOP: begin
            if (loop_cnt_q != '0) begin
              loop_cnt_d = loop_cnt_q - CW'(1);
              bra_d      = 1'b1;
              badr_d     = operand;
              state_d    = S_SQUASH;
            end
          end
          OP_HLT: begin
            hlt_d      = 1'b1;
            halt_cnt_d = CW'(operand);
            state_d    = S_HALT;
          end
          default: begin
`ifdef PCSEQ_ILLEGAL_TRAP_EN
            bra_d     = 1'b1;
            badr_d    = TRAP_ADDR;
            illegal_d = 1'b1;
            state_d   = S_SQUASH;
`endif
          end
        endcase
      end
      // The word fetched here is the delay slot behind a taken branch.
      S_SQUASH: state_d = S_RUN;
      S_HALT: begin
        if (halt_cnt_q == '0) begin
          if (resume) begin
            hlt_d   = 1'b0;
            state_d = S_RUN;
          end
        end else begin
          halt_cnt_d = halt_cnt_q - CW'(1);
          if (halt_cnt_q == CW'(1)) begin
            hlt_d   = 1'b0;
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // rst is active-low despite its name.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_RUN;
      bra_q      <= 1'b0;
      hlt_q      <= 1'b0;
      badr_q     <= '0;
      loop_cnt_q <= '0;
      halt_cnt_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bra_q      <= bra_d;
      hlt_q      <= hlt_d;
      badr_q     <= badr_d;
      loop_cnt_q <= loop_cnt_d;
      halt_cnt_q <= halt_cnt_d;
      illegal_q  <= illegal_d;
    end
  end

  assign BADR      = badr_q;
  assign bra       = bra_q;
  assign hlt       = hlt_q;
  assign busy_loop = (loop_cnt_q != '0);

`ifdef PCSEQ_ILLEGAL_TRAP_EN
  assign illegal = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

endmodule
